// File: rtl/mem_host_loader.sv
// Host-side initiator for the CPU external memory ports: load imem, run the CPU, dump dmem.
// Define CLEAR_DMEM_EN to add a state that zeroes all of dmem before the load phase.
module mem_host_loader #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMEM_DEPTH = 512,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter int unsigned ADDR_STEP  = 4,
  parameter int unsigned RUN_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_start,
  input  logic [9:0]        i_load_len,
  input  logic [10:0]       i_dump_len,
  input  logic [RUN_W-1:0]  i_run_cycles,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_cpu_enable,
  output logic [31:0]       o_addr_ext,
  output logic              o_wen_ext,
  output logic              o_ren_ext,
  output logic [DATA_W-1:0] o_wdata_ext,
  output logic [31:0]       o_addr_ext_2,
  output logic              o_wen_ext_2,
  output logic              o_ren_ext_2,
  output logic [DATA_W-1:0] o_wdata_ext_2,
  input  logic [DATA_W-1:0] i_rdata_ext_2,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned MAX_DEPTH = (IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH;
  localparam int unsigned CNT_W     = $clog2(MAX_DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle, StClear, StLoad, StRun, StDumpReq, StDumpCap, StDumpOut, StDone
  } state_e;

  state_e r_state, w_state_nxt;

  logic [CNT_W-1:0]  r_cnt, r_load_len, r_dump_len;
  logic [RUN_W-1:0]  r_run_cnt, r_run_len;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_valid;

  logic [CNT_W-1:0]  w_load_clamp, w_dump_clamp;
  logic [31:0]       w_cnt_addr;
  logic              w_s_hs, w_m_hs;
  logic              w_load_last, w_run_last, w_dump_last, w_clear_last;

  always_comb begin
    w_load_clamp = (32'(i_load_len) > IMEM_DEPTH) ? CNT_W'(IMEM_DEPTH) : CNT_W'(i_load_len);
    w_dump_clamp = (32'(i_dump_len) > DMEM_DEPTH) ? CNT_W'(DMEM_DEPTH) : CNT_W'(i_dump_len);
  end

  assign w_cnt_addr   = 32'(r_cnt) * ADDR_STEP;
  assign w_s_hs       = (r_state == StLoad) && i_s_valid;
  assign w_m_hs       = (r_state == StDumpOut) && r_m_valid && i_m_ready;
  assign w_load_last  = (r_cnt == r_load_len - CNT_W'(1));
  assign w_dump_last  = (r_cnt == r_dump_len - CNT_W'(1));
  assign w_run_last   = (r_run_cnt == r_run_len - RUN_W'(1));
  assign w_clear_last = (r_cnt == CNT_W'(DMEM_DEPTH - 1));

  // Zero-length phases are skipped by choosing the first non-empty phase that follows.
  function automatic state_e after_load(input logic [RUN_W-1:0] run_len,
                                        input logic [CNT_W-1:0] dump_len);
    if (run_len != '0) return StRun;
    if (dump_len != '0) return StDumpReq;
    return StDone;
  endfunction

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
`ifdef CLEAR_DMEM_EN
          w_state_nxt = StClear;
`else
          w_state_nxt = (w_load_clamp != '0) ? StLoad : after_load(i_run_cycles, w_dump_clamp);
`endif
        end
      end
      StClear: begin
        if (w_clear_last) begin
          w_state_nxt = (r_load_len != '0) ? StLoad : after_load(r_run_len, r_dump_len);
        end
      end
      StLoad: begin
        if (w_s_hs && w_load_last) w_state_nxt = after_load(r_run_len, r_dump_len);
      end
      StRun: begin
        if (w_run_last) w_state_nxt = (r_dump_len != '0) ? StDumpReq : StDone;
      end
      StDumpReq: w_state_nxt = StDumpCap;
      StDumpCap: w_state_nxt = StDumpOut;
      StDumpOut: begin
        if (w_m_hs) w_state_nxt = w_dump_last ? StDone : StDumpReq;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_cnt      <= '0;
      r_load_len <= '0;
      r_dump_len <= '0;
      r_run_len  <= '0;
      r_run_cnt  <= '0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
    end else begin
      if ((r_state == StIdle) && i_start) begin
        r_load_len <= w_load_clamp;
        r_dump_len <= w_dump_clamp;
        r_run_len  <= i_run_cycles;
        r_cnt      <= '0;
        r_run_cnt  <= '0;
      end
      // The shared word counter returns to 0 at the end of every phase it indexes.
      case (r_state)
        StClear: r_cnt <= w_clear_last ? '0 : r_cnt + CNT_W'(1);
        StLoad: begin
          if (w_s_hs) r_cnt <= w_load_last ? '0 : r_cnt + CNT_W'(1);
        end
        StRun: r_run_cnt <= w_run_last ? '0 : r_run_cnt + RUN_W'(1);
        StDumpCap: begin
          r_m_data  <= i_rdata_ext_2;
          r_m_valid <= 1'b1;
        end
        StDumpOut: begin
          if (w_m_hs) begin
            r_m_valid <= 1'b0;
            r_cnt     <= w_dump_last ? '0 : r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so a reset drops them without waiting for a clock.
  always_comb begin
    o_s_ready     = (r_state == StLoad);
    o_wen_ext     = w_s_hs;
    o_wdata_ext   = w_s_hs ? i_s_data : '0;
    o_addr_ext    = w_s_hs ? w_cnt_addr : '0;
    o_ren_ext     = 1'b0;
    o_cpu_enable  = (r_state == StRun);
    o_ren_ext_2   = (r_state == StDumpReq);
    o_addr_ext_2  = (r_state == StDumpReq) ? w_cnt_addr : '0;
    o_wen_ext_2   = 1'b0;
    o_wdata_ext_2 = '0;
`ifdef CLEAR_DMEM_EN
    if (r_state == StClear) begin
      o_wen_ext_2  = 1'b1;
      o_addr_ext_2 = w_cnt_addr;
    end
`endif
    o_m_valid     = r_m_valid;
    o_m_data      = r_m_data;
    o_busy        = (r_state != StIdle);
    o_done        = (r_state == StDone);
  end

endmodule

// File: tb/tb_mem_host_loader.sv
// Directed self-checking bench for mem_host_loader with a behavioural dmem and port monitor.
// Define CLEAR_DMEM_EN to build with the dmem clear phase and an 8-word dmem.
module tb_mem_host_loader;

`ifdef CLEAR_DMEM_EN
  localparam int unsigned TB_DMEM = 8;
`else
  localparam int unsigned TB_DMEM = 1024;
`endif

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  load_len = '0;
  logic [10:0] dump_len = '0;
  logic [15:0] run_cycles = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        cpu_enable;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] rdata_ext_2;
  logic        busy, done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_host_loader #(
    .DATA_W    (32),
    .IMEM_DEPTH(512),
    .DMEM_DEPTH(TB_DMEM),
    .ADDR_STEP (4),
    .RUN_W     (16)
  ) dut (
    .i_clk        (clk),
    .i_arst_n     (arst_n),
    .i_start      (start),
    .i_load_len   (load_len),
    .i_dump_len   (dump_len),
    .i_run_cycles (run_cycles),
    .i_s_valid    (s_valid),
    .o_s_ready    (s_ready),
    .i_s_data     (s_data),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_m_data     (m_data),
    .o_cpu_enable (cpu_enable),
    .o_addr_ext   (addr_ext),
    .o_wen_ext    (wen_ext),
    .o_ren_ext    (ren_ext),
    .o_wdata_ext  (wdata_ext),
    .o_addr_ext_2 (addr_ext_2),
    .o_wen_ext_2  (wen_ext_2),
    .o_ren_ext_2  (ren_ext_2),
    .o_wdata_ext_2(wdata_ext_2),
    .i_rdata_ext_2(rdata_ext_2),
    .o_busy       (busy),
    .o_done       (done)
  );

  // Behavioural dmem; the bench preloads it through its own write port.
  logic [31:0] dmem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) dmem[pre_addr] <= pre_data;
    if (wen_ext_2) dmem[addr_ext_2[11:2]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[11:2]];
  end

  logic [31:0] wr_addr[$], wr_data[$], rd_addr[$], md[$];
  int wr_clr[$];
  int en_cnt = 0, seg_cnt = 0, overlap_cnt = 0, done_cnt = 0, ren_ext_cnt = 0;
  int clr_cnt = 0, clr_bad = 0, clr_sready = 0, clr_seq = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (wen_ext) begin
      wr_addr.push_back(addr_ext);
      wr_data.push_back(wdata_ext);
      wr_clr.push_back(clr_cnt);
    end
    if (ren_ext_2) rd_addr.push_back(addr_ext_2);
    if (m_valid && m_ready) md.push_back(m_data);
    if (cpu_enable) begin
      en_cnt++;
      if (!prev_en) seg_cnt++;
      if (wen_ext || ren_ext || wen_ext_2 || ren_ext_2) overlap_cnt++;
    end
    prev_en = cpu_enable;
    if (done) done_cnt++;
    if (ren_ext) ren_ext_cnt++;
    if (wen_ext_2) begin
      if (wdata_ext_2 !== 32'h0 || addr_ext_2 !== 32'(clr_seq * 4)) clr_bad++;
      clr_seq = (clr_seq + 1) % TB_DMEM;
      clr_cnt++;
      if (s_ready) clr_sready++;
    end
  end

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic preload(input int a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = 10'(a); pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic start_session(input int ld, input int dl, input int rc);
    @(posedge clk); #1;
    load_len = 10'(ld); dump_len = 11'(dl); run_cycles = 16'(rc); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, cpu_enable, s_ready, m_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2} !== 9'b0)
      $display("FAIL reset_strobes got %b want 0",
               {busy, done, cpu_enable, s_ready, m_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2});
    else passed++;
    total++;
    if ({addr_ext, addr_ext_2} !== 64'h0)
      $display("FAIL reset_addr got %h/%h want 0/0", addr_ext, addr_ext_2);
    else passed++;
    total++;
    if ({m_data, wdata_ext, wdata_ext_2} !== 96'h0)
      $display("FAIL reset_data got %h/%h/%h want 0", m_data, wdata_ext, wdata_ext_2);
    else passed++;
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_load();
    logic [31:0] words [0:2];
    int wb, eb, db;
    bit seen;
    words[0] = 32'h2001_0005; words[1] = 32'h2002_0007; words[2] = 32'h0022_1820;
    wb = wr_addr.size(); eb = en_cnt; db = done_cnt;
    start_session(3, 0, 2);
    for (int i = 0; i < 3; i++) push(words[i]);
    wait_done(50, seen);
    total++;
    if (!seen) $display("FAIL load_done got timeout want done pulse");
    else passed++;
    total++;
    if (wr_addr.size() - wb !== 3) $display("FAIL load_count got %0d want 3", wr_addr.size() - wb);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (q_at(wr_addr, wb + i) !== 32'(i * 4))
        $display("FAIL load_addr%0d got %h want %h", i, q_at(wr_addr, wb + i), 32'(i * 4));
      else passed++;
      total++;
      if (q_at(wr_data, wb + i) !== words[i])
        $display("FAIL load_data%0d got %h want %h", i, q_at(wr_data, wb + i), words[i]);
      else passed++;
    end
    total++;
    if (en_cnt - eb !== 2) $display("FAIL load_run got %0d want 2", en_cnt - eb);
    else passed++;
    @(negedge clk);
    total++;
    if (done_cnt - db !== 1 || busy !== 1'b0)
      $display("FAIL load_end got done=%0d busy=%b want 1/0", done_cnt - db, busy);
    else passed++;
  endtask

  task automatic test_bubbles();
    int wb, eb;
    bit seen;
    wb = wr_addr.size(); eb = en_cnt;
    start_session(2, 0, 0);
    push(32'hCAFE_0001);
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || wen_ext !== 1'b0)
      $display("FAIL bubble_ready got s_ready=%b wen=%b want 1/0", s_ready, wen_ext);
    else passed++;
    @(posedge clk); #1;
    push(32'hCAFE_0002);
    wait_done(20, seen);
    total++;
    if (!seen) $display("FAIL bubble_done got timeout want done pulse");
    else passed++;
    total++;
    if (wr_addr.size() - wb !== 2) $display("FAIL bubble_count got %0d want 2", wr_addr.size() - wb);
    else passed++;
    total++;
    if (q_at(wr_addr, wb) !== 32'h0 || q_at(wr_addr, wb + 1) !== 32'h4)
      $display("FAIL bubble_addr got %h,%h want 0,4", q_at(wr_addr, wb), q_at(wr_addr, wb + 1));
    else passed++;
    total++;
    if (q_at(wr_data, wb + 1) !== 32'hCAFE_0002)
      $display("FAIL bubble_data got %h want cafe0002", q_at(wr_data, wb + 1));
    else passed++;
    total++;
    if (en_cnt - eb !== 0) $display("FAIL run_zero got %0d want 0", en_cnt - eb);
    else passed++;
  endtask

  task automatic test_run();
    int eb, sb, ob;
    bit seen;
    eb = en_cnt; sb = seg_cnt; ob = overlap_cnt;
    start_session(0, 0, 10);
    total++;
    if (busy !== 1'b1) $display("FAIL run_busy got %b want 1", busy);
    else passed++;
    wait_done(40, seen);
    total++;
    if (!seen) $display("FAIL run_done got timeout want done pulse");
    else passed++;
    total++;
    if (en_cnt - eb !== 10 || seg_cnt - sb !== 1)
      $display("FAIL run_cycles got %0d in %0d runs want 10 in 1", en_cnt - eb, seg_cnt - sb);
    else passed++;
    total++;
    if (overlap_cnt - ob !== 0) $display("FAIL run_overlap got %0d want 0", overlap_cnt - ob);
    else passed++;
  endtask

  task automatic test_dump();
    logic [31:0] exp0, exp1;
    int rb, db, bad, n;
    bit seen;
`ifdef CLEAR_DMEM_EN
    exp0 = 32'h0; exp1 = 32'h0;
`else
    exp0 = 32'hA; exp1 = 32'hB;
`endif
    preload(0, 32'hA); preload(1, 32'hB); preload(2, 32'hC);
    rb = rd_addr.size(); db = done_cnt;
    m_ready = 1'b0;
    start_session(0, 2, 0);
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 40) begin @(negedge clk); n++; end
    total++;
    if (m_data !== exp0) $display("FAIL dump_word0 got %h want %h", m_data, exp0);
    else passed++;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== exp0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL dump_hold got %0d unstable cycles want 0", bad);
    else passed++;
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0) $display("FAIL dump_drop got m_valid=%b want 0", m_valid);
    else passed++;
    n = 0;
    while (!m_valid && n < 10) begin @(negedge clk); n++; end
    total++;
    if (m_data !== exp1) $display("FAIL dump_word1 got %h want %h", m_data, exp1);
    else passed++;
    @(posedge clk); #1; m_ready = 1'b1;
    wait_done(10, seen);
    m_ready = 1'b0;
    total++;
    if (!seen) $display("FAIL dump_done got timeout want done pulse");
    else passed++;
    total++;
    if (rd_addr.size() - rb !== 2 || q_at(rd_addr, rb) !== 32'h0 || q_at(rd_addr, rb + 1) !== 32'h4)
      $display("FAIL dump_reads got %0d reads %h,%h want 2 reads 0,4",
               rd_addr.size() - rb, q_at(rd_addr, rb), q_at(rd_addr, rb + 1));
    else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt - db !== 1) $display("FAIL dump_done_once got %0d want 1", done_cnt - db);
    else passed++;
  endtask

  task automatic test_start_busy();
    int eb, wb, rb, db, n;
    bit seen;
    eb = en_cnt; wb = wr_addr.size(); rb = rd_addr.size(); db = done_cnt;
    start_session(0, 0, 20);
    n = 0;
    while (!cpu_enable && n < 30) begin @(negedge clk); n++; end
    start_session(2, 3, 5);
    wait_done(60, seen);
    total++;
    if (!seen) $display("FAIL busy_done got timeout want done pulse");
    else passed++;
    total++;
    if (en_cnt - eb !== 20) $display("FAIL busy_run got %0d want 20", en_cnt - eb);
    else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (wr_addr.size() - wb !== 0 || rd_addr.size() - rb !== 0 || done_cnt - db !== 1)
      $display("FAIL busy_ignored got wr=%0d rd=%0d done=%0d want 0/0/1",
               wr_addr.size() - wb, rd_addr.size() - rb, done_cnt - db);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp0;
    int eb, wb, db, n;
    bit seen;
`ifdef CLEAR_DMEM_EN
    exp0 = 32'h0;
`else
    exp0 = 32'hA;
`endif
    db = done_cnt;
    start_session(0, 2, 50);
    n = 0;
    while (!cpu_enable && n < 30) begin @(negedge clk); n++; end
    @(posedge clk); #2;
    arst_n = 1'b0;
    #1;
    total++;
    if (cpu_enable !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_async got en=%b busy=%b want 0/0", cpu_enable, busy);
    else passed++;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt - db !== 0 || busy !== 1'b0)
      $display("FAIL abort_nodone got done=%0d busy=%b want 0/0", done_cnt - db, busy);
    else passed++;
    eb = en_cnt; wb = wr_addr.size(); db = done_cnt;
    start_session(1, 1, 3);
    push(32'h0000_1234);
    m_ready = 1'b1;
    wait_done(60, seen);
    m_ready = 1'b0;
    total++;
    if (!seen) $display("FAIL fresh_done got timeout want done pulse");
    else passed++;
    total++;
    if (en_cnt - eb !== 3) $display("FAIL fresh_run got %0d want 3", en_cnt - eb);
    else passed++;
    total++;
    if (q_at(wr_addr, wb) !== 32'h0 || q_at(wr_data, wb) !== 32'h1234)
      $display("FAIL fresh_load got %h@%h want 1234@0", q_at(wr_data, wb), q_at(wr_addr, wb));
    else passed++;
    total++;
    if (m_data !== exp0) $display("FAIL fresh_dump got %h want %h", m_data, exp0);
    else passed++;
  endtask

`ifdef CLEAR_DMEM_EN
  task automatic test_clear();
    int cb, wb, mb, bb, sb, nz;
    bit seen;
    for (int i = 0; i < 8; i++) preload(i, 32'h100 + 32'(i));
    cb = clr_cnt; wb = wr_addr.size(); mb = md.size(); bb = clr_bad; sb = clr_sready;
    m_ready = 1'b1;
    start_session(1, 8, 0);
    push(32'h55);
    wait_done(100, seen);
    m_ready = 1'b0;
    total++;
    if (!seen) $display("FAIL clear_done got timeout want done pulse");
    else passed++;
    total++;
    if (clr_cnt - cb !== 8 || clr_bad - bb !== 0 || clr_sready - sb !== 0)
      $display("FAIL clear_writes got n=%0d bad=%0d rdy=%0d want 8/0/0",
               clr_cnt - cb, clr_bad - bb, clr_sready - sb);
    else passed++;
    total++;
    if (wr_clr.size() <= wb || wr_clr[wb] !== cb + 8)
      $display("FAIL clear_before_load got %0d clears before load want 8",
               (wr_clr.size() > wb) ? wr_clr[wb] - cb : -1);
    else passed++;
    nz = 0;
    for (int i = mb; i < md.size(); i++) if (md[i] !== 32'h0) nz++;
    total++;
    if (md.size() - mb !== 8 || nz !== 0)
      $display("FAIL clear_dump got %0d words %0d nonzero want 8/0", md.size() - mb, nz);
    else passed++;
  endtask
`endif

  task automatic test_clamp();
    int wb;
    bit seen;
    wb = wr_addr.size();
    start_session(1023, 0, 0);
    for (int i = 0; i < 512; i++) push(32'(i));
    wait_done(20, seen);
    total++;
    if (!seen) $display("FAIL clamp_done got timeout want done after 512 words");
    else passed++;
    total++;
    if (wr_addr.size() - wb !== 512) $display("FAIL clamp_count got %0d want 512", wr_addr.size() - wb);
    else passed++;
    total++;
    if (q_at(wr_addr, wb + 511) !== 32'd2044)
      $display("FAIL clamp_last_addr got %h want 7fc", q_at(wr_addr, wb + 511));
    else passed++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_bubbles();
    test_run();
    test_dump();
    test_start_busy();
    test_reset_mid();
`ifdef CLEAR_DMEM_EN
    test_clear();
`endif
    test_clamp();
    total++;
    if (ren_ext_cnt !== 0) $display("FAIL ren_ext_tied got %0d strobes want 0", ren_ext_cnt);
    else passed++;
`ifndef CLEAR_DMEM_EN
    total++;
    if (clr_cnt !== 0) $display("FAIL wen_ext_2_tied got %0d strobes want 0", clr_cnt);
    else passed++;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
